key_event_ctrl: RTL and testbench

Scan-clock generator and event scheduler for the push-button debounce chain. Produces the slow scan clock that drives every key debounce instance and samples their debounced active-high levels on a safe edge. Converts the levels into press / long-press / repeat / release events and shares a single event output port between all keys by round-robin arbitration with a valid/ready handshake.

---
 rtl/key_event_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// ---------------------------------------------------------------------------
// key_event_ctrl
//
// Scan-clock generator and event scheduler for the push-button debounce
// chain. A free-running divider produces the slow 50 % duty scan clock used
// by every key debounce instance. Debounced key levels are synchronised and
// sampled once per scan period, on the falling edge of scan_clk (the divider
// wrap, called the scan strobe). Sampling there keeps it away from the edge
// on which the debouncers update.
//
// Each key runs a small FSM that turns its level into PRESS / LONG /
// REPEAT / RELEASE events. Each key has a one-deep pending slot. A
// round-robin arbiter moves pending events into a single output register
// that the consumer drains with a valid/ready handshake.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   : a key held past LONG emits REPEAT every REPEAT_TICKS ticks
//   undefined : a held key is silent until release; REPEAT_TICKS is unused
//
// Parameters
//   NKEYS        number of keys (2..16)
//   SCAN_DIV     clk cycles per scan period (even, >= 4)
//   LONG_TICKS   scan ticks held before LONG
//   REPEAT_TICKS scan ticks between REPEAT events after LONG
//
// Ports
//   clk        in   system clock
//   rst_       in   synchronous active-low reset
//   scan_clk   out  scan clock for the debounce instances
//   key_lvl    in   [NKEYS-1:0] debounced levels, 1 = pressed
//   ev_valid   out  event available
//   ev_ready   in   consumer accepts the event
//   ev_key     out  [KW-1:0] key index of the event
//   ev_type    out  [1:0] 0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE
//   ev_overrun out  one-cycle pulse when an event is lost
// ---------------------------------------------------------------------------
module key_event_ctrl #(
  parameter  int NKEYS        = 4,
  parameter  int SCAN_DIV     = 333334,
  parameter  int LONG_TICKS   = 150,
  parameter  int REPEAT_TICKS = 30,
  localparam int KW           = (NKEYS > 2) ? $clog2(NKEYS) : 1
) (
  input  logic             clk,
  input  logic             rst_,
  output logic             scan_clk,
  input  logic [NKEYS-1:0] key_lvl,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [KW-1:0]    ev_key,
  output logic [1:0]       ev_type,
  output logic             ev_overrun
);

  localparam int unsigned NK = NKEYS;

  // Divider
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(SCAN_DIV / 2 - 1);

  // Tick counter sized for the longest interval it has to reach
`ifdef KEY_REPEAT_EN
  localparam int TMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
`else
  localparam int TMAX = LONG_TICKS;
`endif
  localparam int CW = $clog2(TMAX + 1);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_TICKS);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_TICKS);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD
  } key_state_t;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_LONG    = 2'd1,
    EV_REPEAT  = 2'd2,
    EV_RELEASE = 2'd3
  } ev_type_t;

  logic [DW-1:0]    div_q;
  logic             strobe;
  logic [NKEYS-1:0] sync1_q;
  logic [NKEYS-1:0] sync2_q;

  key_state_t       state_q   [NKEYS];
  key_state_t       state_d   [NKEYS];
  logic [CW-1:0]    cnt_q     [NKEYS];
  logic [CW-1:0]    cnt_d     [NKEYS];
  logic [NKEYS-1:0] post;
  ev_type_t         post_type [NKEYS];

  logic [NKEYS-1:0] slot_vld_q;
  logic [NKEYS-1:0] slot_vld_d;
  logic [1:0]       slot_type_q [NKEYS];
  logic [1:0]       slot_type_d [NKEYS];
  logic             lost;

  logic [KW-1:0]    last_q;
  logic             load;
  logic             gnt_found;
  logic [KW-1:0]    gnt_idx;
  logic [1:0]       gnt_type;

  // -------------------------------------------------------------------------
  // Scan divider and scan clock. The strobe is the wrap cycle, which is also
  // the cycle in which scan_clk is driven low.
  // -------------------------------------------------------------------------
  assign strobe = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      div_q    <= '0;
      scan_clk <= 1'b0;
    end else begin
      if (strobe) begin
        div_q    <= '0;
        scan_clk <= 1'b0;
      end else begin
        div_q <= div_q + DW'(1);
        if (div_q == DIV_HALF) begin
          scan_clk <= 1'b1;
        end
      end
    end
  end

  // Two-flop synchroniser for the scan_clk-domain key levels
  always_ff @(posedge clk) begin
    if (!rst_) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_lvl;
      sync2_q <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Per-key FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_) begin
      for (int unsigned k = 0; k < NK; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NK; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Per-key FSM: next state. Release wins over LONG/REPEAT in the same tick.
  always_comb begin
    for (int unsigned k = 0; k < NK; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      if (strobe) begin
        case (state_q[k])
          ST_IDLE: begin
            if (sync2_q[k]) begin
              state_d[k] = ST_PRESSED;
              cnt_d[k]   = '0;
            end
          end
          ST_PRESSED: begin
            if (!sync2_q[k]) begin
              state_d[k] = ST_IDLE;
            end else if ((cnt_q[k] + CW'(1)) == LONG_C) begin
              state_d[k] = ST_HELD;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + CW'(1);
            end
          end
          ST_HELD: begin
            if (!sync2_q[k]) begin
              state_d[k] = ST_IDLE;
            end
`ifdef KEY_REPEAT_EN
            else if ((cnt_q[k] + CW'(1)) == REP_C) begin
              cnt_d[k] = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + CW'(1);
            end
`endif
          end
          default: begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end
        endcase
      end
    end
  end

  // Per-key FSM: event posting
  always_comb begin
    for (int unsigned k = 0; k < NK; k++) begin
      post[k]      = 1'b0;
      post_type[k] = EV_PRESS;
      if (strobe) begin
        case (state_q[k])
          ST_IDLE: begin
            if (sync2_q[k]) begin
              post[k]      = 1'b1;
              post_type[k] = EV_PRESS;
            end
          end
          ST_PRESSED: begin
            if (!sync2_q[k]) begin
              post[k]      = 1'b1;
              post_type[k] = EV_RELEASE;
            end else if ((cnt_q[k] + CW'(1)) == LONG_C) begin
              post[k]      = 1'b1;
              post_type[k] = EV_LONG;
            end
          end
          ST_HELD: begin
            if (!sync2_q[k]) begin
              post[k]      = 1'b1;
              post_type[k] = EV_RELEASE;
            end
`ifdef KEY_REPEAT_EN
            else if ((cnt_q[k] + CW'(1)) == REP_C) begin
              post[k]      = 1'b1;
              post_type[k] = EV_REPEAT;
            end
`endif
          end
          default: begin
            post[k] = 1'b0;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin arbiter: search starts one past the last granted key.
  // -------------------------------------------------------------------------
  assign load = !ev_valid || ev_ready;

  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_type  = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NK; i++) begin
      cand = (32'(last_q) + 32'd1 + i) % NK;
      if (!gnt_found && slot_vld_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = KW'(cand);
        gnt_type  = slot_type_q[cand];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pending slots. The grant clears first, then the FSM post is applied, so a
  // post into a slot granted this cycle lands in an empty slot.
  // -------------------------------------------------------------------------
  always_comb begin
    lost = 1'b0;
    for (int unsigned k = 0; k < NK; k++) begin
      slot_vld_d[k]  = slot_vld_q[k];
      slot_type_d[k] = slot_type_q[k];
      if (load && gnt_found && (gnt_idx == KW'(k))) begin
        slot_vld_d[k] = 1'b0;
      end
      if (post[k]) begin
        if (!slot_vld_d[k]) begin
          slot_vld_d[k]  = 1'b1;
          slot_type_d[k] = post_type[k];
        end else begin
          lost = 1'b1;
          if (post_type[k] != EV_REPEAT) begin
            slot_type_d[k] = post_type[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      slot_vld_q <= '0;
      for (int unsigned k = 0; k < NK; k++) begin
        slot_type_q[k] <= '0;
      end
    end else begin
      slot_vld_q <= slot_vld_d;
      for (int unsigned k = 0; k < NK; k++) begin
        slot_type_q[k] <= slot_type_d[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register and overrun pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_) begin
      ev_valid   <= 1'b0;
      ev_key     <= '0;
      ev_type    <= '0;
      ev_overrun <= 1'b0;
      last_q     <= KW'(NKEYS - 1);
    end else begin
      ev_overrun <= lost;
      if (load) begin
        ev_valid <= gnt_found;
        if (gnt_found) begin
          ev_key  <= gnt_idx;
          ev_type <= gnt_type;
          last_q  <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for key_event_ctrl (NKEYS=4, SCAN_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2).
// A reference model derives each key's events from how many consecutive scan
// ticks it has been seen pressed, queues granted events, and a negedge
// monitor checks the DUT outputs against the model.
// ---------------------------------------------------------------------------
module tb_key_event_ctrl;

  localparam int NK = 4;
  localparam int SD = 4;
  localparam int LT = 3;
  localparam int RT = 2;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        scan_clk;
  logic [3:0]  key_lvl = 4'hF;
  logic        ev_valid;
  logic        ev_ready = 1'b1;
  logic [1:0]  ev_key;
  logic [1:0]  ev_type;
  logic        ev_overrun;

  key_event_ctrl #(
    .NKEYS        (NK),
    .SCAN_DIV     (SD),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .scan_clk   (scan_clk),
    .key_lvl    (key_lvl),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_key     (ev_key),
    .ev_type    (ev_type),
    .ev_overrun (ev_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] key;
    logic [1:0] typ;
  } ev_t;

  ev_t        exp_q[$];
  int         compared   = 0;
  int         mismatched = 0;

  // Reference model state
  int         m_div;
  logic [3:0] m_s1, m_s2;
  int         m_run  [NK];
  bit         pend_v [NK];
  logic [1:0] pend_t [NK];
  int         m_last;
  bit         m_ov;
  bit         exp_valid, exp_ovr, exp_scan;
  bit         m_rst_seen = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_div = 0;
    m_s1  = '0;
    m_s2  = '0;
    for (int k = 0; k < NK; k++) begin
      m_run[k]  = 0;
      pend_v[k] = 1'b0;
      pend_t[k] = '0;
    end
    m_last    = NK - 1;
    m_ov      = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_scan  = 1'b0;
    exp_q.delete();
  endfunction

  // Model: one step per clock edge, using the inputs present at that edge
  always @(posedge clk) begin : model
    bit   strobe, load, found, lost;
    int   k, r, ev;
    ev_t  e;
    if (!rst_) begin
      model_reset();
      m_rst_seen = 1'b1;
    end else begin
      m_rst_seen = 1'b0;
      strobe = (m_div == SD - 1);
      load   = !m_ov || ev_ready;
      found  = 1'b0;
      if (load) begin
        for (int i = 1; i <= NK; i++) begin
          k = (m_last + i) % NK;
          if (!found && pend_v[k]) begin
            found     = 1'b1;
            e.key     = 2'(k);
            e.typ     = pend_t[k];
            exp_q.push_back(e);
            pend_v[k] = 1'b0;
            m_last    = k;
          end
        end
        m_ov = found;
      end
      lost = 1'b0;
      if (strobe) begin
        for (int j = 0; j < NK; j++) begin
          ev = -1;
          if (m_s2[j]) begin
            m_run[j]++;
            r = m_run[j];
            if (r == 1) ev = 0;
            else if (r - 1 == LT) ev = 1;
            else if (REP_EN && (r - 1 > LT) && ((r - 1 - LT) % RT == 0)) ev = 2;
          end else begin
            if (m_run[j] > 0) ev = 3;
            m_run[j] = 0;
          end
          if (ev >= 0) begin
            if (!pend_v[j]) begin
              pend_v[j] = 1'b1;
              pend_t[j] = 2'(ev);
            end else begin
              lost = 1'b1;
              if (ev != 2) pend_t[j] = 2'(ev);
            end
          end
        end
      end
      exp_ovr   = lost;
      exp_valid = m_ov;
      m_s2      = m_s1;
      m_s1      = key_lvl;
      m_div     = strobe ? 0 : m_div + 1;
      exp_scan  = (m_div >= SD / 2);
    end
  end

  // Monitor: compares on the falling edge, pops on each accepted event
  always @(negedge clk) begin
    if (m_rst_seen) begin
      chk("rst_ev_valid",   ev_valid,   0);
      chk("rst_ev_key",     ev_key,     0);
      chk("rst_ev_type",    ev_type,    0);
      chk("rst_ev_overrun", ev_overrun, 0);
      chk("rst_scan_clk",   scan_clk,   0);
    end else begin
      chk("scan_clk",   scan_clk,   exp_scan);
      chk("ev_valid",   ev_valid,   exp_valid);
      chk("ev_overrun", ev_overrun, exp_ovr);
      if (ev_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("ev_pending", exp_q.size(), 1);
        end else begin
          chk("ev_key",  ev_key,  exp_q[0].key);
          chk("ev_type", ev_type, exp_q[0].typ);
          if (ev_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [1:0] idx;
    // Reset with all keys down: first events must be PRESS 0,1,2,3
    step(5);
    rst_ = 1'b1;
    // All keys held, ready toggling: continuous REPEAT traffic and rotation
    for (int i = 0; i < 60; i++) begin
      ev_ready = 1'($urandom_range(0, 1));
      step(1);
    end
    ev_ready = 1'b1;
    key_lvl  = 4'h0;
    step(40);
    // Single press on key 1 for 12 strobes
    key_lvl = 4'b0010;
    step(48);
    key_lvl = 4'b0000;
    step(20);
    // Backpressure with keys 0 and 2 pressed together
    ev_ready = 1'b0;
    key_lvl  = 4'b0101;
    step(8);
    ev_ready = 1'b1;
    step(4);
    key_lvl = 4'b0000;
    step(20);
    // Press then release of key 3 before the consumer accepts
    ev_ready = 1'b0;
    key_lvl  = 4'b1000;
    step(4);
    key_lvl = 4'b0000;
    step(8);
    ev_ready = 1'b1;
    step(8);
    // LONG pending while stalled, following REPEAT must be dropped
    ev_ready = 1'b0;
    key_lvl  = 4'b0001;
    step(28);
    ev_ready = 1'b1;
    step(4);
    key_lvl = 4'b0000;
    step(16);
    // Randomised traffic with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        idx = 2'($urandom_range(0, 3));
        key_lvl[idx] = ~key_lvl[idx];
      end
      if ($urandom_range(0, 7) == 0) ev_ready = ~ev_ready;
      if (i == 1500) rst_ = 1'b0;
      if (i == 1503) rst_ = 1'b1;
      step(1);
    end
    // Drain
    key_lvl  = 4'h0;
    ev_ready = 1'b1;
    step(40);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
